rv32_data_bus_ctrl: RTL and testbench

Sequencing controller for the core's data bus. It accepts one data request at a time from the core and decodes its address into one of `NUM_TGT` targets (main memory plus MMIO devices). It strobes only the selected target, waits for that target's done with a bounded timeout, and returns a single registered response with data and an error flag. It replaces the free-running done-OR and registered bus-selector arrangement in the top level with an explicit one-outstanding-transaction state machine.

---
 rtl/rv32_data_bus_ctrl.sv | 131 +++++++++++++
 tb/tb_rv32_data_bus_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_data_bus_ctrl.sv
// Data bus sequencer: decodes one core request to a target,
// waits for its done with a bounded timeout, returns one response.
module rv32_data_bus_ctrl #(
  parameter int NUM_TGT = 2,
  parameter logic [NUM_TGT*32-1:0] TGT_BASE =
    {32'h0000_0000, 32'h8000_0000},
  parameter logic [NUM_TGT*32-1:0] TGT_MASK =
    {32'hF000_0000, 32'hF000_0000},
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  input  logic                  req_write,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  output logic [NUM_TGT-1:0]    tgt_valid,
  output logic [31:0]           tgt_addr,
  output logic                  tgt_write,
  output logic [31:0]           tgt_wdata,
  output logic [3:0]            tgt_wstrb,
  input  logic [NUM_TGT-1:0]    tgt_done,
  input  logic [NUM_TGT*32-1:0] tgt_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Base/mask lists are written target 0 first (MSB end).
  function automatic logic [31:0] base_of(int i);
    return TGT_BASE[(NUM_TGT-1-i)*32 +: 32];
  endfunction

  function automatic logic [31:0] mask_of(int i);
    return TGT_MASK[(NUM_TGT-1-i)*32 +: 32];
  endfunction

  logic [1:0]         state;
  logic [IW-1:0]      sel;
  logic [CW-1:0]      cnt;
  logic               hit;
  logic [IW-1:0]      hit_idx;
  logic [NUM_TGT-1:0] hit_oh;
  logic               done_sel;
  logic [31:0]        rdata_sel;
  logic               timed_out;

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if ((req_addr & mask_of(i)) == base_of(i)) begin
        hit       = 1'b1;
        hit_idx   = IW'(i);
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  assign done_sel  = tgt_done[sel];
  assign rdata_sel = tgt_rdata[32*int'(sel) +: 32];
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sel       <= '0;
      cnt       <= '0;
      tgt_valid <= '0;
      tgt_addr  <= '0;
      tgt_write <= 1'b0;
      tgt_wdata <= '0;
      tgt_wstrb <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      tgt_valid <= '0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            tgt_addr  <= req_addr;
            tgt_write <= req_write;
            tgt_wdata <= req_wdata;
            tgt_wstrb <= req_wstrb;
            if (hit) begin
              sel       <= hit_idx;
              cnt       <= '0;
              tgt_valid <= hit_oh;
              state     <= S_WAIT;
            end else begin
              resp_data <= '0;
              resp_err  <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (done_sel) begin
            resp_data <= tgt_write ? 32'h0 : rdata_sel;
            resp_err  <= 1'b0;
            state     <= S_RESP;
          end else if (timed_out) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            state     <= S_RESP;
          end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_data_bus_ctrl.sv
// Directed bench for rv32_data_bus_ctrl with TIMEOUT=8:
// idle, load, store, unmapped, timeout and reset mid-wait.
module tb_rv32_data_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [1:0]  tgt_valid;
  logic [31:0] tgt_addr;
  logic        tgt_write;
  logic [31:0] tgt_wdata;
  logic [3:0]  tgt_wstrb;
  logic [1:0]  tgt_done;
  logic [63:0] tgt_rdata;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32_data_bus_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .tgt_valid(tgt_valid),
    .tgt_addr(tgt_addr), .tgt_write(tgt_write),
    .tgt_wdata(tgt_wdata), .tgt_wstrb(tgt_wstrb),
    .tgt_done(tgt_done), .tgt_rdata(tgt_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_wstrb = s;
  endtask

  task automatic req_off();
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_wstrb = '0;
  endtask

  initial begin
    reset = 1'b1;
    req_off();
    tgt_done  = '0;
    tgt_rdata = '0;
    step();
    step();
    reset = 1'b0;

    // Idle with stray done pulses
    for (int i = 0; i < 10; i++) begin
      tgt_done = (i % 3 == 1) ? 2'b11 : 2'b00;
      step();
      chk("idle_ready", 32'(req_ready), 32'd1);
      chk("idle_resp", 32'(resp_valid), 32'd0);
      chk("idle_tv", 32'(tgt_valid), 32'd0);
    end
    tgt_done = '0;
    chk("rst_taddr", tgt_addr, 32'h0);
    chk("rst_rdata", resp_data, 32'h0);

    // Load from memory, done in strobe cycle
    req(32'h0000_0100, 1'b0, 32'h0, 4'h0);
    chk("ld_ready", 32'(req_ready), 32'd1);
    step();
    req_off();
    chk("ld_tv", 32'(tgt_valid), 32'h1);
    chk("ld_taddr", tgt_addr, 32'h0000_0100);
    chk("ld_twrite", 32'(tgt_write), 32'd0);
    chk("ld_nordy", 32'(req_ready), 32'd0);
    tgt_done  = 2'b01;
    tgt_rdata = {32'hFFFF_0000, 32'h1234_5678};
    step();
    tgt_done = '0;
    chk("ld_tv_off", 32'(tgt_valid), 32'h0);
    chk("ld_rv", 32'(resp_valid), 32'd1);
    chk("ld_data", resp_data, 32'h1234_5678);
    chk("ld_err", 32'(resp_err), 32'd0);
    chk("ld_rsp_rdy", 32'(req_ready), 32'd0);
    step();
    chk("ld_rv_off", 32'(resp_valid), 32'd0);
    chk("ld_idle", 32'(req_ready), 32'd1);

    // Store to MMIO, done 3 cycles after strobe
    req(32'h8000_0004, 1'b1, 32'hA5A5_A5A5, 4'hF);
    step();
    req_off();
    chk("st_tv", 32'(tgt_valid), 32'h2);
    chk("st_wdata", tgt_wdata, 32'hA5A5_A5A5);
    chk("st_wstrb", 32'(tgt_wstrb), 32'hF);
    chk("st_write", 32'(tgt_write), 32'd1);
    tgt_done = 2'b01;
    step();
    chk("st_tv_off", 32'(tgt_valid), 32'h0);
    chk("st_ign0", 32'(resp_valid), 32'd0);
    tgt_done = 2'b00;
    step();
    chk("st_wait", 32'(resp_valid), 32'd0);
    step();
    chk("st_hold", tgt_wdata, 32'hA5A5_A5A5);
    tgt_done  = 2'b11;
    tgt_rdata = {32'hDEAD_BEEF, 32'h1111_1111};
    step();
    tgt_done = '0;
    chk("st_rv", 32'(resp_valid), 32'd1);
    chk("st_data", resp_data, 32'h0);
    chk("st_err", 32'(resp_err), 32'd0);
    step();

    // Unmapped address
    req(32'h4000_0000, 1'b0, 32'h0, 4'h0);
    step();
    req_off();
    chk("um_tv", 32'(tgt_valid), 32'h0);
    chk("um_rv", 32'(resp_valid), 32'd1);
    chk("um_err", 32'(resp_err), 32'd1);
    chk("um_data", resp_data, 32'h0);
    step();
    chk("um_idle", 32'(req_ready), 32'd1);

    // Timeout with no done: response in accept+9
    req(32'h0000_0200, 1'b0, 32'h0, 4'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      req_off();
      chk("to_norsp", 32'(resp_valid), 32'd0);
    end
    step();
    chk("to_rv", 32'(resp_valid), 32'd1);
    chk("to_err", 32'(resp_err), 32'd1);
    chk("to_data", resp_data, 32'h0);
    step();

    // Done in the last WAIT cycle still wins
    req(32'h0000_0204, 1'b0, 32'h0, 4'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      req_off();
      chk("tl_norsp", 32'(resp_valid), 32'd0);
    end
    tgt_done  = 2'b01;
    tgt_rdata = {32'h0, 32'hCAFE_F00D};
    step();
    tgt_done = '0;
    chk("tl_rv", 32'(resp_valid), 32'd1);
    chk("tl_err", 32'(resp_err), 32'd0);
    chk("tl_data", resp_data, 32'hCAFE_F00D);
    step();

    // Reset two cycles after accept, then a late done
    req(32'h0000_0300, 1'b0, 32'h0, 4'h0);
    step();
    req_off();
    step();
    reset = 1'b1;
    step();
    reset    = 1'b0;
    tgt_done = 2'b01;
    chk("mr_rv", 32'(resp_valid), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd1);
    chk("mr_taddr", tgt_addr, 32'h0);
    chk("mr_tv", 32'(tgt_valid), 32'h0);
    step();
    tgt_done = '0;
    chk("mr_late", 32'(resp_valid), 32'd0);
    chk("mr_ready2", 32'(req_ready), 32'd1);

    // Normal load afterwards, done one cycle after strobe
    req(32'h0000_0400, 1'b0, 32'h0, 4'h0);
    step();
    req_off();
    chk("pr_tv", 32'(tgt_valid), 32'h1);
    step();
    chk("pr_wait", 32'(resp_valid), 32'd0);
    tgt_done  = 2'b01;
    tgt_rdata = {32'h0, 32'h0BAD_F00D};
    step();
    tgt_done = '0;
    chk("pr_rv", 32'(resp_valid), 32'd1);
    chk("pr_data", resp_data, 32'h0BAD_F00D);
    chk("pr_err", 32'(resp_err), 32'd0);
    step();
    chk("pr_idle", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
